// File: rtl/phase_seq_deser_if.sv
// Bus bundle between the phase/deserializer feeder and its consumer.
// The master side drives the controls; the slave side is the block itself.
interface phase_seq_deser_if #(
    parameter int PHASE_W = 3,
    parameter int DATA_W  = 4,
    parameter int FCNT_W  = 8
);
    logic               enable;
    logic               sync_in;
    logic               ser_in;
    logic [PHASE_W-1:0] clk_out;
    logic [DATA_W-1:0]  a0;
    logic               a0_valid;
    logic               frame_done;
    logic [FCNT_W-1:0]  frame_cnt;

    modport master (
        output enable, sync_in, ser_in,
        input  clk_out, a0, a0_valid, frame_done, frame_cnt
    );

    modport slave (
        input  enable, sync_in, ser_in,
        output clk_out, a0, a0_valid, frame_done, frame_cnt
    );
endinterface

// File: rtl/phase_seq_deser.sv
// Free-running phase counter plus serial-to-parallel word assembly.
// Bits enter on phases 0..DATA_W-1; the word is published on the last of those.
module phase_seq_deser #(
    parameter int PHASE_W = 3,
    parameter int DATA_W  = 4,
    parameter int FCNT_W  = 8
) (
    input logic              clk,
    input logic              rst,
    phase_seq_deser_if.slave bus
);
    localparam logic [PHASE_W-1:0] LOAD_PH = PHASE_W'(DATA_W - 1);
    localparam logic [PHASE_W-1:0] LAST_PH = '1;

    logic [PHASE_W-1:0] phase;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  word;
    logic               loaded;
    logic               done;
    logic [FCNT_W-1:0]  fcnt;
    logic [DATA_W-1:0]  shift_nxt;
    logic               advance;
    logic               in_load;

    assign shift_nxt = {shift[DATA_W-2:0], bus.ser_in};
    assign advance   = bus.enable && !bus.sync_in;
    assign in_load   = phase <= LOAD_PH;

    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (bus.enable)
            phase <= bus.sync_in ? '0 : phase + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            shift <= '0;
        else if (bus.enable && bus.sync_in)
            shift <= '0;
        else if (advance && in_load)
            shift <= shift_nxt;
    end

    // A sync landing on the load phase leaves the previous word in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            word   <= '0;
            loaded <= 1'b0;
        end else if (advance && phase == LOAD_PH) begin
            word   <= shift_nxt;
            loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            fcnt <= '0;
        end else begin
            done <= advance && phase == LAST_PH;
            if (advance && phase == LAST_PH)
                fcnt <= fcnt + 1'b1;
        end
    end

    assign bus.clk_out    = phase;
    assign bus.a0         = word;
    assign bus.a0_valid   = loaded && phase[PHASE_W-1];
    assign bus.frame_done = done;
    assign bus.frame_cnt  = fcnt;
endmodule
